// File: rtl/hilo_muldiv_sequencer_if.sv
// Hi/Lo sequencer handshake: EX-side operation request,
// architectural Hi/Lo and the stall/status returned to the pipeline.
interface hilo_muldiv_sequencer_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [2:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             rd_hilo;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    logic             busy;
    logic             stall;
    logic             div_by_zero;

    modport master (
        output start, op, a, b, rd_hilo,
        input  hi_out, lo_out, busy, stall, div_by_zero
    );

    modport slave (
        input  start, op, a, b, rd_hilo,
        output hi_out, lo_out, busy, stall, div_by_zero
    );
endinterface

// File: rtl/hilo_muldiv_sequencer.sv
// Multi-cycle mult/div sequencer owning Hi/Lo for EX:
// shift-add multiplier, restoring divider, one bit per cycle.
module hilo_muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input logic clk,
    input logic rst,
    hilo_muldiv_sequencer_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MADD  = 3'b100;
    localparam logic [2:0] OP_MSUB  = 3'b101;
    localparam logic [2:0] OP_MTHI  = 3'b110;
    localparam logic [2:0] OP_MTLO  = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DIV, FIN} state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      cnt_q;
    logic [2:0]         op_q;
    logic               neg_q;
    logic               neg_rem_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [WIDTH-1:0]   mplier_q;
    logic [WIDTH-1:0]   quo_q;
    logic [WIDTH-1:0]   dvsr_q;
    logic [WIDTH-1:0]   rem_q;
    logic [WIDTH-1:0]   hi_q;
    logic [WIDTH-1:0]   lo_q;
    logic               dbz_q;

    logic               is_mul, is_div, is_signed;
    logic               is_mthi, is_mtlo;
    logic               a_neg, b_neg, b_zero;
    logic [WIDTH-1:0]   a_mag, b_mag;
    logic               last_iter;
    logic [WIDTH:0]     shifted, trial;
    logic               trial_ok;
    logic [2*WIDTH-1:0] prod, fin_hilo;
    logic [WIDTH-1:0]   quo_fix, rem_fix;

    always_comb begin
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_signed = 1'b0;
        is_mthi   = 1'b0;
        is_mtlo   = 1'b0;
        unique case (bus.op)
            OP_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MULTU: is_mul = 1'b1;
            OP_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
            OP_DIVU:  is_div = 1'b1;
            OP_MADD:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MSUB:  begin is_mul = 1'b1; is_signed = 1'b1; end
            OP_MTHI:  is_mthi = 1'b1;
            OP_MTLO:  is_mtlo = 1'b1;
        endcase
    end

    assign a_neg     = is_signed & bus.a[WIDTH-1];
    assign b_neg     = is_signed & bus.b[WIDTH-1];
    assign a_mag     = a_neg ? -bus.a : bus.a;
    assign b_mag     = b_neg ? -bus.b : bus.b;
    assign b_zero    = (bus.b == '0);
    assign last_iter = (cnt_q == CW'(WIDTH - 1));

    // Restoring step: bring in the next dividend bit, keep it if it fits.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign trial    = shifted - {1'b0, dvsr_q};
    assign trial_ok = ~trial[WIDTH];

    always_comb begin
        prod    = neg_q ? -acc_q : acc_q;
        quo_fix = neg_q ? -quo_q : quo_q;
        rem_fix = neg_rem_q ? -rem_q : rem_q;
        unique case (op_q)
            OP_MADD: fin_hilo = {hi_q, lo_q} + prod;
            OP_MSUB: fin_hilo = {hi_q, lo_q} - prod;
            OP_DIV,
            OP_DIVU: fin_hilo = {rem_fix, quo_fix};
            default: fin_hilo = prod;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start && is_mul)                state_d = MUL;
                else if (bus.start && is_div && !b_zero) state_d = DIV;
            end
            MUL:  if (last_iter) state_d = FIN;
            DIV:  if (last_iter) state_d = FIN;
            FIN:  state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.busy        = (state_q != IDLE);
        bus.stall       = bus.busy & (bus.start | bus.rd_hilo);
        bus.hi_out      = hi_q;
        bus.lo_out      = lo_q;
        bus.div_by_zero = dbz_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q     <= '0;
            op_q      <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
            mcand_q   <= '0;
            acc_q     <= '0;
            mplier_q  <= '0;
            quo_q     <= '0;
            dvsr_q    <= '0;
            rem_q     <= '0;
            hi_q      <= '0;
            lo_q      <= '0;
            dbz_q     <= 1'b0;
        end else begin
            dbz_q <= 1'b0;
            unique case (state_q)
                IDLE: if (bus.start) begin
                    if (is_mthi) hi_q <= bus.a;
                    if (is_mtlo) lo_q <= bus.a;
                    if (is_mul) begin
                        mcand_q  <= {{WIDTH{1'b0}}, a_mag};
                        mplier_q <= b_mag;
                        acc_q    <= '0;
                        neg_q    <= a_neg ^ b_neg;
                        op_q     <= bus.op;
                        cnt_q    <= '0;
                    end
                    if (is_div && b_zero) begin
                        dbz_q <= 1'b1;
                    end else if (is_div) begin
                        quo_q     <= a_mag;
                        dvsr_q    <= b_mag;
                        rem_q     <= '0;
                        neg_q     <= a_neg ^ b_neg;
                        neg_rem_q <= a_neg;
                        op_q      <= bus.op;
                        cnt_q     <= '0;
                    end
                end
                MUL: begin
                    if (mplier_q[0]) acc_q <= acc_q + mcand_q;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q + CW'(1);
                end
                DIV: begin
                    rem_q <= trial_ok ? trial[WIDTH-1:0]
                                      : shifted[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], trial_ok};
                    cnt_q <= cnt_q + CW'(1);
                end
                FIN: {hi_q, lo_q} <= fin_hilo;
            endcase
        end
    end
endmodule
